// File: rtl/handshake_clocking_pkg.sv
// rtl/handshake_clocking_pkg.sv - shared limits, beat counter width and saturating increment for valid_clocking
package handshake_clocking_pkg;

    localparam int STAGES_MIN   = 1;
    localparam int STAGES_MAX   = 16;
    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 1024;
    localparam int BEAT_COUNT_W = 32;

    localparam logic [BEAT_COUNT_W-1:0] BEAT_COUNT_MAX = '1;

    function automatic logic [BEAT_COUNT_W-1:0] sat_inc(input logic [BEAT_COUNT_W-1:0] value);
        return (value == BEAT_COUNT_MAX) ? value : value + BEAT_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/valid_clocking_stage.sv
// rtl/valid_clocking_stage.sv - one forward register stage: flag plus payload, loaded on advance
module valid_clocking_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             adv,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // Payload is only captured alongside a valid flag so idle beats never disturb data_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (adv) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/valid_clocking.sv
// rtl/valid_clocking.sv - STAGES-deep forward-registered valid/ready slice with bubble collapse; optional beat_count under VALID_CLOCKING_STATS_EN
module valid_clocking
    import handshake_clocking_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    master_valid,
    input  logic [WIDTH-1:0]        master_data,
    output logic                    master_ready,
    output logic                    slave_valid,
    output logic [WIDTH-1:0]        slave_data,
    input  logic                    slave_ready,
    output logic                    busy
`ifdef VALID_CLOCKING_STATS_EN
    ,
    output logic [BEAT_COUNT_W-1:0] beat_count
`endif
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] adv;

    // A stage may move when it is empty or when everything downstream of it moves.
    always_comb begin
        adv             = '0;
        adv[STAGES-1]   = ~valid_q[STAGES-1] | slave_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~valid_q[i] | adv[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_data;

        if (i == 0) begin : g_head
            assign in_valid = master_valid;
            assign in_data  = master_data;
        end else begin : g_body
            assign in_valid = valid_q[i-1];
            assign in_data  = data_q[i-1];
        end

        valid_clocking_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_data  (in_data),
            .adv      (adv[i]),
            .valid_q  (valid_q[i]),
            .data_q   (data_q[i])
        );
    end

    assign master_ready = adv[0];
    assign slave_valid  = valid_q[STAGES-1];
    assign slave_data   = data_q[STAGES-1];
    assign busy         = |valid_q;

`ifdef VALID_CLOCKING_STATS_EN
    logic [BEAT_COUNT_W-1:0] beat_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q <= '0;
        end else if (slave_valid && slave_ready) begin
            beat_count_q <= sat_inc(beat_count_q);
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_valid_clocking.sv
// tb/tb_valid_clocking.sv - directed and scoreboard checks of valid_clocking (STAGES=2 and 3); beat_count checks under VALID_CLOCKING_STATS_EN
module tb_valid_clocking;

    localparam int N_RAND = 10000;

    logic        clk;
    logic        rst_n;

    logic        m_valid2, m_ready2, s_valid2, s_ready2, busy2;
    logic [31:0] m_data2, s_data2;
    logic        m_valid3, m_ready3, s_valid3, s_ready3, busy3;
    logic [31:0] m_data3, s_data3;
`ifdef VALID_CLOCKING_STATS_EN
    logic [31:0] beat_count2, beat_count3;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    valid_clocking #(.WIDTH(32), .STAGES(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .master_valid (m_valid2),
        .master_data  (m_data2),
        .master_ready (m_ready2),
        .slave_valid  (s_valid2),
        .slave_data   (s_data2),
        .slave_ready  (s_ready2),
        .busy         (busy2)
`ifdef VALID_CLOCKING_STATS_EN
        ,
        .beat_count   (beat_count2)
`endif
    );

    valid_clocking #(.WIDTH(32), .STAGES(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .master_valid (m_valid3),
        .master_data  (m_data3),
        .master_ready (m_ready3),
        .slave_valid  (s_valid3),
        .slave_data   (s_data3),
        .slave_ready  (s_ready3),
        .busy         (busy3)
`ifdef VALID_CLOCKING_STATS_EN
        ,
        .beat_count   (beat_count3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input logic mv, input logic [31:0] md, input logic sr);
        m_valid2 = mv;
        m_data2  = md;
        s_ready2 = sr;
        @(negedge clk);
    endtask

    task automatic drain();
        m_valid2 = 1'b0;
        m_valid3 = 1'b0;
        s_ready2 = 1'b1;
        s_ready3 = 1'b1;
        repeat (5) next_cycle();
    endtask

    initial begin
        logic [31:0] q[$];
        logic        hold_v;
        logic [31:0] hold_d;
        int          sent, rcvd, cyc;

        rst_n    = 1'b0;
        m_valid2 = 1'b0; m_data2 = '0; s_ready2 = 1'b0;
        m_valid3 = 1'b0; m_data3 = '0; s_ready3 = 1'b0;
        #1;
        check("rst_slave_valid", s_valid2, 0);
        check("rst_slave_data",  s_data2,  0);
        check("rst_busy",        busy2,    0);
        check("rst_master_ready", m_ready2, 1);
        repeat (2) next_cycle();
        rst_n = 1'b1;

        // Back-to-back beats, no stall: data appears two cycles after handshake.
        for (int c = 0; c < 12; c++) begin
            set2(c < 8, 32'(c + 1), 1'b1);
            check("t1_master_ready", m_ready2, 1);
            check("t1_slave_valid", s_valid2, (c >= 2 && c < 10) ? 1 : 0);
            if (c >= 2 && c < 10) check("t1_slave_data", s_data2, 32'(c - 1));
            next_cycle();
        end
        drain();

        // Fill under stall, then release: 0xC enters as 0xA leaves.
        set2(1'b1, 32'hA, 1'b0);
        check("t2_ready_c0", m_ready2, 1);
        next_cycle();
        set2(1'b1, 32'hB, 1'b0);
        check("t2_ready_c1", m_ready2, 1);
        next_cycle();
        set2(1'b1, 32'hC, 1'b0);
        check("t2_ready_full", m_ready2, 0);
        check("t2_valid_c2", s_valid2, 1);
        check("t2_data_c2", s_data2, 32'hA);
        next_cycle();
        set2(1'b1, 32'hC, 1'b0);
        check("t2_ready_c3", m_ready2, 0);
        check("t2_data_stable", s_data2, 32'hA);
        next_cycle();
        set2(1'b1, 32'hC, 1'b1);
        check("t2_ready_swap", m_ready2, 1);
        check("t2_data_a", s_data2, 32'hA);
        next_cycle();
        set2(1'b0, 32'h0, 1'b1);
        check("t2_valid_b", s_valid2, 1);
        check("t2_data_b", s_data2, 32'hB);
        next_cycle();
        set2(1'b0, 32'h0, 1'b1);
        check("t2_valid_c", s_valid2, 1);
        check("t2_data_c", s_data2, 32'hC);
        next_cycle();
        set2(1'b0, 32'h0, 1'b1);
        check("t2_valid_empty", s_valid2, 0);
        check("t2_busy_empty", busy2, 0);
        next_cycle();
        drain();

        // Bubble collapse on the 3-stage slice.
        s_ready3 = 1'b0;
        m_valid3 = 1'b1; m_data3 = 32'h5;
        next_cycle();
        m_valid3 = 1'b0;
        repeat (2) next_cycle();
        m_valid3 = 1'b1; m_data3 = 32'h6;
        @(negedge clk);
        check("t3_valid_5", s_valid3, 1);
        check("t3_data_5", s_data3, 32'h5);
        check("t3_ready_6", m_ready3, 1);
        next_cycle();
        m_data3 = 32'h7;
        @(negedge clk);
        check("t3_ready_7", m_ready3, 1);
        next_cycle();
        m_valid3 = 1'b0;
        @(negedge clk);
        check("t3_ready_full", m_ready3, 0);
        check("t3_data_held", s_data3, 32'h5);
        next_cycle();
        s_ready3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t3_drain_valid", s_valid3, (c < 3) ? 1 : 0);
            if (c < 3) check("t3_drain_data", s_data3, 32'(5 + c));
            next_cycle();
        end

        // Reset with two beats in flight.
        set2(1'b1, 32'h11, 1'b0);
        next_cycle();
        set2(1'b1, 32'h12, 1'b0);
        next_cycle();
        set2(1'b0, 32'h0, 1'b0);
        check("t4_busy_before", busy2, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", s_valid2, 0);
        check("t4_rst_data", s_data2, 0);
        check("t4_rst_busy", busy2, 0);
        check("t4_rst_ready", m_ready2, 1);
        #1;
        rst_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            set2(c == 0, 32'h9, 1'b1);
            check("t4_valid", s_valid2, (c == 2) ? 1 : 0);
            if (c == 2) check("t4_data", s_data2, 32'h9);
            next_cycle();
        end
        drain();

        // Random traffic against a scoreboard.
        hold_v = 1'b0; hold_d = '0;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < N_RAND && cyc < 60000) begin
            m_valid2 = (sent < N_RAND) && ($urandom_range(0, 1) == 1);
            m_data2  = $urandom;
            s_ready2 = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (hold_v) begin
                check("rand_stall_valid", s_valid2, 1);
                check("rand_stall_data", s_data2, hold_d);
            end
            if (m_valid2 && m_ready2) begin
                q.push_back(m_data2);
                sent++;
            end
            if (s_valid2 && s_ready2) begin
                if (q.size() == 0) check("rand_spurious", s_valid2, 0);
                else check("rand_data", s_data2, q.pop_front());
                rcvd++;
            end
            hold_v = s_valid2 && !s_ready2;
            hold_d = s_data2;
            next_cycle();
            cyc++;
        end
        check("rand_received", 32'(rcvd), 32'(N_RAND));
        check("rand_leftover", 32'(q.size()), 0);
        drain();

`ifdef VALID_CLOCKING_STATS_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check("stats_reset", beat_count2, 0);
        for (int c = 0; c < 100; c++) begin
            m_valid2 = 1'b1; m_data2 = 32'(c); s_ready2 = 1'b1;
            next_cycle();
        end
        drain();
        check("stats_100", beat_count2, 100);
        force u_dut2.beat_count_q = 32'hFFFF_FFFD;
        #1;
        release u_dut2.beat_count_q;
        for (int c = 0; c < 6; c++) begin
            m_valid2 = 1'b1; m_data2 = 32'(c); s_ready2 = 1'b1;
            next_cycle();
        end
        drain();
        check("stats_saturate", beat_count2, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
